// File: rtl/cpu_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_wb_pkg
// Purpose  : Shared writeback-stage encodings: source select, load extension
//            select, bypass record and extension helpers.
// Revision : 1.0
// ============================================================================
package cpu_wb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RAW  = 5;

  typedef enum logic [2:0] {
    WB_ALU     = 3'd0,
    WB_MEM     = 3'd1,
    WB_PC4     = 3'd2,
    WB_HI      = 3'd3,
    WB_LO      = 3'd4,
    WB_HILO_LO = 3'd5,
    WB_RSV6    = 3'd6,
    WB_RSV7    = 3'd7
  } wb_src_e;

  typedef enum logic [1:0] {
    EXT_WORD = 2'd0,
    EXT_SB   = 2'd1,
    EXT_SH   = 2'd2,
    EXT_UB   = 2'd3
  } ext_sel_e;

  typedef struct packed {
    logic            valid;
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] data;
  } fwd_t;

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
    return {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
    return {{(XLEN-16){h[15]}}, h};
  endfunction

  function automatic logic [XLEN-1:0] zext8(input logic [7:0] b);
    return {{(XLEN-8){1'b0}}, b};
  endfunction

endpackage : cpu_wb_pkg
`default_nettype wire

// File: rtl/wb_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_unit_if
// Purpose  : Pipeline-side bundle of the writeback stage (controls, operands,
//            register-file write port, HI/LO, bypass and retire counter).
// Revision : 1.0
// ============================================================================
interface wb_writeback_unit_if;
  import cpu_wb_pkg::*;

  logic              Stall;
  logic              RegWrite2WB;
  logic              RegWriteCtrl;
  logic              Move;
  logic              Zero;
  logic              HiLoWrite;
  logic [1:0]        SEMux;
  logic [2:0]        MemToReg;
  logic [XLEN-1:0]   PCPlus4;
  logic [XLEN-1:0]   ALUResult;
  logic [XLEN-1:0]   MemReadData;
  logic [2*XLEN-1:0] HiLoResult;
  logic [RAW-1:0]    RegDstResult;

  logic              oWrEn;
  logic [RAW-1:0]    oWrAddr;
  logic [XLEN-1:0]   oWrData;
  logic [XLEN-1:0]   oHi;
  logic [XLEN-1:0]   oLo;
  logic              oFwdValid;
  logic [RAW-1:0]    oFwdAddr;
  logic [XLEN-1:0]   oFwdData;
  logic [XLEN-1:0]   oRetireCount;

  modport master (
    output Stall, RegWrite2WB, RegWriteCtrl, Move, Zero, HiLoWrite,
           SEMux, MemToReg, PCPlus4, ALUResult, MemReadData, HiLoResult,
           RegDstResult,
    input  oWrEn, oWrAddr, oWrData, oHi, oLo, oFwdValid, oFwdAddr,
           oFwdData, oRetireCount
  );

  modport slave (
    input  Stall, RegWrite2WB, RegWriteCtrl, Move, Zero, HiLoWrite,
           SEMux, MemToReg, PCPlus4, ALUResult, MemReadData, HiLoResult,
           RegDstResult,
    output oWrEn, oWrAddr, oWrData, oHi, oLo, oFwdValid, oFwdAddr,
           oFwdData, oRetireCount
  );

endinterface : wb_writeback_unit_if
`default_nettype wire

// File: rtl/wb_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_ext
// Purpose  : Combinational load-data extender (word / signed byte /
//            signed half / unsigned byte).
// Revision : 1.0
// ============================================================================
module wb_load_ext
  import cpu_wb_pkg::*;
(
  input  logic [1:0]      SEMux_i,
  input  logic [XLEN-1:0] Data_i,
  output logic [XLEN-1:0] Ext_o
);

  always_comb begin
    Ext_o = Data_i;
    case (SEMux_i)
      EXT_WORD: Ext_o = Data_i;
      EXT_SB:   Ext_o = sext8(Data_i[7:0]);
      EXT_SH:   Ext_o = sext16(Data_i[15:0]);
      EXT_UB:   Ext_o = zext8(Data_i[7:0]);
      default:  Ext_o = Data_i;
    endcase
  end

endmodule : wb_load_ext
`default_nettype wire

// File: rtl/wb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_unit
// Purpose  : Writeback stage: register-file write port, HI/LO registers,
//            registered last-write bypass and retired-instruction counter.
// Revision : 1.0
// ============================================================================
module wb_writeback_unit
  import cpu_wb_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  wb_writeback_unit_if.slave bus
);

  logic            commit;
  logic            wr_en;
  logic [XLEN-1:0] ext_data;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] hi_q = '0;
  logic [XLEN-1:0] lo_q = '0;
  fwd_t            fwd_q = '0;
  logic [XLEN-1:0] retire_q = '0;

  logic [XLEN-1:0] hi_d;
  logic [XLEN-1:0] lo_d;
  fwd_t            fwd_d;
  logic [XLEN-1:0] retire_d;

  assign commit = bus.RegWrite2WB & ~bus.Stall;

  // Register $0 is hardwired, so a true conditional move to it is still dropped.
  assign wr_en = ~Reset & commit & bus.RegWriteCtrl
               & (~bus.Move | bus.Zero)
               & (bus.RegDstResult != '0);

  wb_load_ext u_load_ext (
    .SEMux_i (bus.SEMux),
    .Data_i  (bus.MemReadData),
    .Ext_o   (ext_data)
  );

  // HI/LO sources read the registered values, not a same-cycle HiLoWrite.
  always_comb begin
    wr_data = bus.ALUResult;
    case (bus.MemToReg)
      WB_ALU:     wr_data = bus.ALUResult;
      WB_MEM:     wr_data = ext_data;
      WB_PC4:     wr_data = bus.PCPlus4;
      WB_HI:      wr_data = hi_q;
      WB_LO:      wr_data = lo_q;
      WB_HILO_LO: wr_data = bus.HiLoResult[XLEN-1:0];
      default:    wr_data = bus.ALUResult;
    endcase
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    fwd_d    = fwd_q;
    retire_d = retire_q;
    if (!bus.Stall) begin
      fwd_d.valid = wr_en;
      fwd_d.addr  = bus.RegDstResult;
      fwd_d.data  = wr_data;
    end
    if (commit && bus.HiLoWrite) begin
      hi_d = bus.HiLoResult[2*XLEN-1:XLEN];
      lo_d = bus.HiLoResult[XLEN-1:0];
    end
    if (commit) begin
      retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      fwd_q    <= '0;
      retire_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      fwd_q    <= fwd_d;
      retire_q <= retire_d;
    end
  end

  assign bus.oWrEn        = wr_en;
  assign bus.oWrAddr      = bus.RegDstResult;
  assign bus.oWrData      = wr_data;
  assign bus.oHi          = hi_q;
  assign bus.oLo          = lo_q;
  assign bus.oFwdValid    = fwd_q.valid;
  assign bus.oFwdAddr     = fwd_q.addr;
  assign bus.oFwdData     = fwd_q.data;
  assign bus.oRetireCount = retire_q;

endmodule : wb_writeback_unit
`default_nettype wire

// File: tb/tb_wb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_writeback_unit
// Purpose  : Self-checking bench for wb_writeback_unit against a behavioural
//            model of the writeback rules.
// Revision : 1.0
// ============================================================================
module tb_wb_writeback_unit;

  logic Clk;
  logic Reset;

  wb_writeback_unit_if bus ();

  wb_writeback_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [31:0] m_hi  = 32'h0;
  logic [31:0] m_lo  = 32'h0;
  logic        m_fv  = 1'b0;
  logic [4:0]  m_fa  = 5'h0;
  logic [31:0] m_fd  = 32'h0;
  logic [31:0] m_cnt = 32'h0;

  function automatic logic m_wren();
    return (Reset == 1'b0) && bus.RegWrite2WB && !bus.Stall && bus.RegWriteCtrl
           && (!bus.Move || bus.Zero) && (bus.RegDstResult != 5'd0);
  endfunction

  function automatic logic [31:0] m_ext();
    int unsigned v;
    case (bus.SEMux)
      2'd0: return bus.MemReadData;
      2'd1: begin
        v = bus.MemReadData & 32'hFF;
        return (v >= 128) ? v - 256 : v;
      end
      2'd2: begin
        v = bus.MemReadData & 32'hFFFF;
        return (v >= 32768) ? v - 65536 : v;
      end
      default: return bus.MemReadData & 32'hFF;
    endcase
  endfunction

  function automatic logic [31:0] m_wrdata();
    case (bus.MemToReg)
      3'd1:    return m_ext();
      3'd2:    return bus.PCPlus4;
      3'd3:    return m_hi;
      3'd4:    return m_lo;
      3'd5:    return bus.HiLoResult[31:0];
      default: return bus.ALUResult;
    endcase
  endfunction

  // One rising edge, with the model advanced from the pre-edge inputs.
  task automatic tick();
    logic        we;
    logic [31:0] wd;
    logic [4:0]  wa;
    logic        c;
    we = m_wren();
    wd = m_wrdata();
    wa = bus.RegDstResult;
    c  = bus.RegWrite2WB && !bus.Stall;
    @(posedge Clk);
    if (Reset) begin
      m_hi = 0; m_lo = 0; m_fv = 0; m_fa = 0; m_fd = 0; m_cnt = 0;
    end else if (!bus.Stall) begin
      m_fv = we; m_fa = wa; m_fd = wd;
      if (c && bus.HiLoWrite) begin
        m_hi = bus.HiLoResult[63:32];
        m_lo = bus.HiLoResult[31:0];
      end
      if (c) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic set_write(input logic [2:0] src, input logic [4:0] dst);
    Reset = 0; bus.Stall = 0; bus.RegWrite2WB = 1; bus.RegWriteCtrl = 1;
    bus.Move = 0; bus.Zero = 0; bus.HiLoWrite = 0;
    bus.MemToReg = src; bus.RegDstResult = dst;
  endtask

  task automatic rand_inputs();
    Reset            = ($urandom_range(0, 31) == 0);
    bus.Stall        = ($urandom_range(0, 4) == 0);
    bus.RegWrite2WB  = ($urandom_range(0, 3) != 0);
    bus.RegWriteCtrl = ($urandom_range(0, 3) != 0);
    bus.Move         = ($urandom_range(0, 2) == 0);
    bus.Zero         = 1'($urandom);
    bus.HiLoWrite    = ($urandom_range(0, 3) == 0);
    bus.SEMux        = 2'($urandom);
    bus.MemToReg     = 3'($urandom);
    bus.PCPlus4      = $urandom;
    bus.ALUResult    = $urandom;
    bus.MemReadData  = $urandom;
    bus.HiLoResult   = {$urandom, $urandom};
    bus.RegDstResult = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
  endtask

  task automatic test_init();
    #1;
    n_checks++;
    if (bus.oRetireCount !== 32'h0 || bus.oHi !== 32'h0 || bus.oLo !== 32'h0 || bus.oFwdValid !== 1'b0)
      $display("FAIL init_zero act=cnt %0h hi %0h lo %0h fv %0b req=0", bus.oRetireCount, bus.oHi, bus.oLo, bus.oFwdValid);
    else n_pass++;
  endtask

  task automatic test_reset();
    set_write(3'd0, 5'd3);
    bus.HiLoWrite = 1; bus.HiLoResult = 64'hDEAD_BEEF_CAFE_F00D;
    Reset = 1;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b0) $display("FAIL reset_wren act=%0b req=0", bus.oWrEn);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oHi !== 32'h0 || bus.oLo !== 32'h0) $display("FAIL reset_hilo act=%0h/%0h req=0/0", bus.oHi, bus.oLo);
    else n_pass++;
    n_checks++;
    if (bus.oRetireCount !== 32'h0) $display("FAIL reset_count act=%0h req=0", bus.oRetireCount);
    else n_pass++;
    n_checks++;
    if (bus.oFwdValid !== 1'b0 || bus.oFwdAddr !== 5'h0 || bus.oFwdData !== 32'h0)
      $display("FAIL reset_fwd act=%0b/%0h/%0h req=0/0/0", bus.oFwdValid, bus.oFwdAddr, bus.oFwdData);
    else n_pass++;
    Reset = 0;
  endtask

  task automatic test_load_ext();
    set_write(3'd1, 5'd7);
    bus.SEMux = 2'd1; bus.MemReadData = 32'h0000_00F0;
    #1;
    n_checks++;
    if (bus.oWrData !== 32'hFFFF_FFF0 || bus.oWrEn !== 1'b1)
      $display("FAIL ext_sb act=%0h en %0b req=fffffff0 en 1", bus.oWrData, bus.oWrEn);
    else n_pass++;
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        bus.SEMux = 2'(s); bus.MemReadData = $urandom;
        #1;
        n_checks++;
        if (bus.oWrData !== m_ext()) $display("FAIL ext_sel%0d act=%0h req=%0h", s, bus.oWrData, m_ext());
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_cmov();
    set_write(3'd0, 5'd5);
    bus.ALUResult = 32'h1234_5678; bus.Move = 1; bus.Zero = 0;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b0) $display("FAIL cmov_false act=%0b req=0", bus.oWrEn);
    else n_pass++;
    tick();
    bus.Zero = 1;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b1) $display("FAIL cmov_true act=%0b req=1", bus.oWrEn);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oFwdAddr !== 5'd5 || bus.oFwdValid !== 1'b1 || bus.oFwdData !== 32'h1234_5678)
      $display("FAIL cmov_fwd act=%0b/%0h/%0h req=1/5/12345678", bus.oFwdValid, bus.oFwdAddr, bus.oFwdData);
    else n_pass++;
    bus.RegDstResult = 5'd0;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b0) $display("FAIL cmov_r0 act=%0b req=0", bus.oWrEn);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oFwdValid !== 1'b0) $display("FAIL r0_fwd_valid act=%0b req=0", bus.oFwdValid);
    else n_pass++;
  endtask

  task automatic test_hilo();
    set_write(3'd0, 5'd9);
    bus.HiLoWrite = 1; bus.HiLoResult = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    bus.HiLoResult = 64'h1111_2222_3333_4444; bus.MemToReg = 3'd3;
    #1;
    n_checks++;
    if (bus.oWrData !== 32'hAAAA_BBBB) $display("FAIL hilo_old_hi act=%0h req=aaaabbbb", bus.oWrData);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oHi !== 32'h1111_2222 || bus.oLo !== 32'h3333_4444)
      $display("FAIL hilo_load act=%0h/%0h req=11112222/33334444", bus.oHi, bus.oLo);
    else n_pass++;
    n_checks++;
    if (bus.oFwdData !== 32'hAAAA_BBBB) $display("FAIL hilo_fwd act=%0h req=aaaabbbb", bus.oFwdData);
    else n_pass++;
    bus.HiLoWrite = 0; bus.MemToReg = 3'd4;
    #1;
    n_checks++;
    if (bus.oWrData !== 32'h3333_4444) $display("FAIL lo_read act=%0h req=33334444", bus.oWrData);
    else n_pass++;
    bus.MemToReg = 3'd5; bus.HiLoResult = 64'h5555_6666_7777_8888;
    #1;
    n_checks++;
    if (bus.oWrData !== 32'h7777_8888) $display("FAIL hilo_lo_src act=%0h req=77778888", bus.oWrData);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] s_hi, s_lo, s_fd, s_cnt;
    logic        s_fv;
    logic [4:0]  s_fa;
    s_hi = m_hi; s_lo = m_lo; s_fv = m_fv; s_fa = m_fa; s_fd = m_fd; s_cnt = m_cnt;
    set_write(3'd2, 5'd17);
    bus.PCPlus4 = 32'h0040_0010; bus.HiLoWrite = 1; bus.HiLoResult = 64'h9999_8888_7777_6666;
    bus.Stall = 1;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b0) $display("FAIL stall_wren act=%0b req=0", bus.oWrEn);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.oHi !== s_hi || bus.oLo !== s_lo || bus.oRetireCount !== s_cnt)
      $display("FAIL stall_hold act=%0h/%0h/%0h req=%0h/%0h/%0h", bus.oHi, bus.oLo, bus.oRetireCount, s_hi, s_lo, s_cnt);
    else n_pass++;
    n_checks++;
    if (bus.oFwdValid !== s_fv || bus.oFwdAddr !== s_fa || bus.oFwdData !== s_fd)
      $display("FAIL stall_fwd act=%0b/%0h/%0h req=%0b/%0h/%0h", bus.oFwdValid, bus.oFwdAddr, bus.oFwdData, s_fv, s_fa, s_fd);
    else n_pass++;
    bus.Stall = 0;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b1 || bus.oWrData !== 32'h0040_0010)
      $display("FAIL release_wr act=%0b/%0h req=1/00400010", bus.oWrEn, bus.oWrData);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oRetireCount !== s_cnt + 32'd1 || bus.oHi !== 32'h9999_8888 || bus.oFwdAddr !== 5'd17)
      $display("FAIL release_commit act=%0h/%0h/%0h req=%0h/99998888/11", bus.oRetireCount, bus.oHi, bus.oFwdAddr, s_cnt + 32'd1);
    else n_pass++;
  endtask

  task automatic test_bubble();
    logic [31:0] s_cnt, s_hi;
    s_cnt = m_cnt; s_hi = m_hi;
    set_write(3'd0, 5'd4);
    bus.RegWrite2WB = 0; bus.HiLoWrite = 1; bus.HiLoResult = 64'h0BAD_0BAD_0BAD_0BAD;
    #1;
    n_checks++;
    if (bus.oWrEn !== 1'b0) $display("FAIL bubble_wren act=%0b req=0", bus.oWrEn);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oFwdValid !== 1'b0 || bus.oRetireCount !== s_cnt || bus.oHi !== s_hi)
      $display("FAIL bubble_state act=%0b/%0h/%0h req=0/%0h/%0h", bus.oFwdValid, bus.oRetireCount, bus.oHi, s_cnt, s_hi);
    else n_pass++;
  endtask

  task automatic test_wrap();
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    m_cnt = 32'hFFFF_FFFF;
    set_write(3'd0, 5'd2);
    #1;
    n_checks++;
    if (bus.oRetireCount !== 32'hFFFF_FFFF) $display("FAIL wrap_preload act=%0h req=ffffffff", bus.oRetireCount);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.oRetireCount !== 32'h0) $display("FAIL wrap_count act=%0h req=0", bus.oRetireCount);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      #1;
      n_checks++;
      if (bus.oWrEn !== m_wren()) $display("FAIL rnd_wren i=%0d act=%0b req=%0b", i, bus.oWrEn, m_wren());
      else n_pass++;
      n_checks++;
      if (bus.oWrData !== m_wrdata() || bus.oWrAddr !== bus.RegDstResult)
        $display("FAIL rnd_wrdata i=%0d act=%0h@%0h req=%0h@%0h", i, bus.oWrData, bus.oWrAddr, m_wrdata(), bus.RegDstResult);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.oHi !== m_hi || bus.oLo !== m_lo)
        $display("FAIL rnd_hilo i=%0d act=%0h/%0h req=%0h/%0h", i, bus.oHi, bus.oLo, m_hi, m_lo);
      else n_pass++;
      n_checks++;
      if (bus.oFwdValid !== m_fv || bus.oFwdAddr !== m_fa || bus.oFwdData !== m_fd)
        $display("FAIL rnd_fwd i=%0d act=%0b/%0h/%0h req=%0b/%0h/%0h", i, bus.oFwdValid, bus.oFwdAddr, bus.oFwdData, m_fv, m_fa, m_fd);
      else n_pass++;
      n_checks++;
      if (bus.oRetireCount !== m_cnt) $display("FAIL rnd_count i=%0d act=%0h req=%0h", i, bus.oRetireCount, m_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    Reset = 0;
    bus.Stall = 0; bus.RegWrite2WB = 0; bus.RegWriteCtrl = 0; bus.Move = 0;
    bus.Zero = 0; bus.HiLoWrite = 0; bus.SEMux = 0; bus.MemToReg = 0;
    bus.PCPlus4 = 0; bus.ALUResult = 0; bus.MemReadData = 0; bus.HiLoResult = 0;
    bus.RegDstResult = 0;
    test_init();
    test_reset();
    test_load_ext();
    test_cmov();
    test_hilo();
    test_stall();
    test_bubble();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_wb_writeback_unit
`default_nettype wire
